alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
Parametrised successor to the EX-stage ALU source muxes. Selects both ALU operands (A and B) independently from register, MEM-forward, WB-forward or extended-immediate sources. Registers the results into a stallable, flushable pipeline slot feeding the ALU. Also keeps a debugger-visible issue counter and a freezable operand snapshot.

Parameters:
DATA_W, 32, operand/datapath width in bits
IMM_W, 16, immediate field width; must be <= DATA_W
CNT_W, 16, width of the issued-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
reg_a_i  input  DATA_W  register-file value for operand A
reg_b_i  input  DATA_W  register-file value for operand B
fwd_mem_i  input  DATA_W  forwarded ALU result from MEM stage
fwd_wb_i  input  DATA_W  forwarded result from WB stage
imm_i  input  IMM_W  raw immediate field
zext_i  input  1  1 = zero-extend imm_i, 0 = sign-extend
sel_a_i  input  2  operand A source: 00 reg_a, 01 fwd_mem, 10 fwd_wb, 11 immediate
sel_b_i  input  2  operand B source, same encoding with reg_b
valid_i  input  1  a real instruction is presented this cycle
stall_i  input  1  hold the slot contents
flush_i  input  1  invalidate the slot (bubble)
dbg_freeze_i  input  1  freeze the debug snapshot
dbg_clr_i  input  1  synchronous clear of the issue counter
op_a_o  output  DATA_W  registered operand A
op_b_o  output  DATA_W  registered operand B
valid_o  output  1  registered valid
dbg_cnt_o  output  CNT_W  number of valid operations loaded
dbg_snap_a_o  output  DATA_W  last valid operand A loaded while not frozen
dbg_snap_b_o  output  DATA_W  last valid operand B loaded while not frozen

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0 immediately and hold at 0 while rst_n is low.
- Immediate extension (combinational):
  - zext_i=1: upper DATA_W-IMM_W bits are 0.
  - zext_i=0: upper bits replicate imm_i[IMM_W-1].
  - If IMM_W == DATA_W, the immediate passes through unchanged.
- Selection is combinational. A and B selects are fully independent; both may pick the same source.
- Slot register updates on the rising clk edge with priority flush > stall > load:
  - flush_i=1: valid_o<=0, op_a_o<=0, op_b_o<=0. This holds regardless of stall_i and valid_i.
  - stall_i=1 (no flush): op_a_o, op_b_o and valid_o hold their values.
  - Otherwise (load): op_a_o/op_b_o <= selected values, valid_o <= valid_i. Operands load even when valid_i=0.
- Latency: exactly one cycle from inputs to op_*_o when loading.
- A "valid load" is a load cycle (no flush, no stall) with valid_i=1.
- Issue counter:
  - Increments by 1 on each valid load.
  - Wraps from 2^CNT_W-1 to 0.
  - dbg_clr_i=1 sets the counter to 0 and takes priority over a simultaneous increment.
  - Stall and flush cycles never count.
- Snapshot:
  - On a valid load with dbg_freeze_i=0, dbg_snap_a_o/b_o capture the same values loaded into op_a_o/op_b_o.
  - With dbg_freeze_i=1 the snapshot holds. The slot and counter keep operating.
  - Flush does not clear the snapshot.
- No state machine beyond the slot, counter and snapshot registers. No combinational path from inputs to any output.
- Reset asserted mid-operation discards the in-flight slot. The first cycle after reset release behaves as a normal load cycle.

Test Plan:
- Reset, then load each source in turn: reg_a=0x11, fwd_mem=0x22, fwd_wb=0x33, imm=0x8001, zext=0, with sel_a=00/01/10/11 and valid_i=1 -> one cycle later op_a_o = 0x11, 0x22, 0x33, 0xFFFF8001; dbg_cnt_o = 4.
- Extension and independent selects: imm=0x8001, zext=1, sel_a=11, sel_b=01, fwd_mem=0xDEADBEEF -> op_a_o=0x00008001, op_b_o=0xDEADBEEF.
- Stall then flush: load A=0x5 with valid, then stall_i=1 for 3 cycles while changing inputs -> op_a_o stays 0x5 and valid_o stays 1, count +1 only. Then flush_i=1 together with stall_i=1 -> op_a_o=0, valid_o=0, count unchanged.
- Counter: with CNT_W=4, issue 17 valid loads -> dbg_cnt_o=1. Assert dbg_clr_i together with a valid load -> dbg_cnt_o=0.
- Snapshot: load B=0xAA valid, set dbg_freeze_i=1, load B=0xBB valid -> op_b_o=0xBB, dbg_snap_b_o=0xAA. Release freeze and load 0xCC -> dbg_snap_b_o=0xCC.
- Async reset: drop rst_n between clock edges while valid_o=1 and dbg_cnt_o=7 -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// EX-stage operand selection for both ALU inputs, registered into a stallable and
// flushable slot. Also provides a debug issue counter and a freezable operand snapshot.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] reg_a_i,
    input  logic [DATA_W-1:0] reg_b_i,
    input  logic [DATA_W-1:0] fwd_mem_i,
    input  logic [DATA_W-1:0] fwd_wb_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              zext_i,
    input  logic [1:0]        sel_a_i,
    input  logic [1:0]        sel_b_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              dbg_freeze_i,
    input  logic              dbg_clr_i,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  dbg_cnt_o,
    output logic [DATA_W-1:0] dbg_snap_a_o,
    output logic [DATA_W-1:0] dbg_snap_b_o
);

    // The fill loop is empty when IMM_W == DATA_W, so the immediate passes through.
    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                     input logic zext);
        logic [DATA_W-1:0] res;
        logic              fill;
        res  = DATA_W'(imm);
        fill = zext ? 1'b0 : imm[IMM_W-1];
        for (int i = IMM_W; i < DATA_W; i++) begin
            res[i] = fill;
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] pick_src(input logic [1:0]        sel,
                                                   input logic [DATA_W-1:0] reg_val,
                                                   input logic [DATA_W-1:0] mem_val,
                                                   input logic [DATA_W-1:0] wb_val,
                                                   input logic [DATA_W-1:0] imm_val);
        logic [DATA_W-1:0] res;
        case (sel)
            2'b00:   res = reg_val;
            2'b01:   res = mem_val;
            2'b10:   res = wb_val;
            2'b11:   res = imm_val;
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic              load_s;
    logic              valid_load_s;

    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic              valid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] snap_a_r;
    logic [DATA_W-1:0] snap_b_r;

    // Operand selection and slot-update qualifiers.
    always_comb begin
        imm_ext_s    = extend_imm(imm_i, zext_i);
        sel_a_s      = pick_src(sel_a_i, reg_a_i, fwd_mem_i, fwd_wb_i, imm_ext_s);
        sel_b_s      = pick_src(sel_b_i, reg_b_i, fwd_mem_i, fwd_wb_i, imm_ext_s);
        load_s       = !flush_i && !stall_i;
        valid_load_s = load_s && valid_i;
    end

    // Pipeline slot: flush beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r  <= {DATA_W{1'b0}};
            op_b_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (flush_i) begin
            op_a_r  <= {DATA_W{1'b0}};
            op_b_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (stall_i) begin
            op_a_r  <= op_a_r;
            op_b_r  <= op_b_r;
            valid_r <= valid_r;
        end else begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            valid_r <= valid_i;
        end
    end

    // Issue counter; clear wins over a same-cycle increment, wrap is natural.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (dbg_clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (valid_load_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Debug snapshot of the last valid operands loaded while not frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_a_r <= {DATA_W{1'b0}};
            snap_b_r <= {DATA_W{1'b0}};
        end else if (valid_load_s && !dbg_freeze_i) begin
            snap_a_r <= sel_a_s;
            snap_b_r <= sel_b_s;
        end else begin
            snap_a_r <= snap_a_r;
            snap_b_r <= snap_b_r;
        end
    end

    assign op_a_o       = op_a_r;
    assign op_b_o       = op_b_r;
    assign valid_o      = valid_r;
    assign dbg_cnt_o    = cnt_r;
    assign dbg_snap_a_o = snap_a_r;
    assign dbg_snap_b_o = snap_b_r;

endmodule
